// File: rtl/regbus_pkg.sv
// Shared types and default sizing for the register-bus master and its command queue.
package regbus_pkg;

  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Queue entry layout at default widths; the master packs entries in this same order.
  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/regbus_cmd_fifo.sv
// Synchronous command queue with full/empty flags; push is refused when full, pop when empty.
module regbus_cmd_fifo
  import regbus_pkg::*;
#(
  parameter int WIDTH = $bits(cmd_t),
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regbus_master.sv
// Register-bus master: queues commands, runs them one at a time on the bus, returns responses.
// Optional read timeout is enabled by defining REGBUS_MASTER_TIMEOUT_EN.
module regbus_master
  import regbus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds
  // its payload stable while valid is high and ready is low.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  chip_select,
  output logic                  write_en,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  data_valid,
  output logic [1:0]            state_dbg
);

  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  state_t                state;
  state_t                state_nxt;
  logic [CMD_W-1:0]      fifo_wdata;
  logic [CMD_W-1:0]      fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  ready_q;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  rd_done;
  logic                  to_hit;

  // ready_q keeps cmd_ready low while reset is held and for the cycle it is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign cmd_ready  = ready_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_write, cmd_addr, cmd_wdata};
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign head_write = fifo_rdata[CMD_W-1];

  regbus_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_done = (state == ST_RD) && data_valid;

`ifdef REGBUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;

  // Counts RD cycles; the count is zero on entry because RD is always entered from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               to_cnt <= '0;
    else if (state != ST_RD)  to_cnt <= '0;
    else                      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state == ST_RD) && !data_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_q <= 1'b0;
    else if ((state == ST_WR) || rd_done) err_q <= 1'b0;
    else if (to_hit)                      err_q <= 1'b1;
  end

  assign rsp_err = err_q;
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = head_write ? ST_WR : ST_RD;
      ST_WR:   state_nxt = ST_RESP;
      ST_RD:   if (data_valid || to_hit) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    chip_select = (state == ST_WR) || (state == ST_RD);
    write_en    = (state == ST_WR);
    read_en     = (state == ST_RD);
    addr        = chip_select ? cur_addr : '0;
    write_data  = write_en ? cur_wdata : '0;
    rsp_valid   = (state == ST_RESP);
    state_dbg   = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      cur_wdata <= '0;
    end else if (fifo_pop) begin
      cur_addr  <= fifo_rdata[CMD_W-2 -: ADDR_WIDTH];
      cur_wdata <= fifo_rdata[DATA_WIDTH-1:0];
    end
  end

  // Response payload is captured on the cycle the bus access completes and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else if (state == ST_WR) begin
      rsp_write <= 1'b1;
      rsp_rdata <= '0;
    end else if (rd_done) begin
      rsp_write <= 1'b0;
      rsp_rdata <= read_data;
    end else if (to_hit) begin
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_regbus_master.sv
// Directed bench for regbus_master with a register-file responder model and bus/response monitors.
module tb_regbus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_ready;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  addr;
  logic        chip_select, write_en, read_en;
  logic [31:0] write_data, read_data;
  logic        data_valid;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regbus_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .addr(addr), .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
    .write_data(write_data), .read_data(read_data), .data_valid(data_valid),
    .state_dbg(state_dbg)
  );

  // Responder: combinational read data, data_valid registered one cycle after read_en.
  logic [31:0] regs [256];
  bit          written [256];
  bit          dv_q;
  bit          resp_en = 1'b1;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h08:   return 32'h12345678;
      8'h20:   return 32'hA5A50020;
      8'h30:   return 32'h0BADF00D;
      default: return {24'h0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    dv_q <= read_en && resp_en;
    if (write_en) begin
      regs[addr]    <= write_data;
      written[addr] <= 1'b1;
    end
  end

  assign data_valid = dv_q;
  assign read_data  = read_en ? (written[addr] ? regs[addr] : init_val(addr)) : 32'h0;

  // Monitors: bus access starts (cs rising), completed responses, and write/read overlap.
  logic [40:0] act_q[$];
  logic [40:0] exp_q[$];
  logic [33:0] rsp_q[$];
  logic [33:0] exp_rsp_q[$];
  bit          cs_prev = 1'b0;
  int          excl_bad = 0;

  always @(posedge clk) begin
    if (chip_select && !cs_prev) act_q.push_back({write_en, addr, write_data});
    cs_prev = chip_select;
    if (write_en && read_en) excl_bad++;
    if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_write, rsp_err, rsp_rdata});
  end

  // Called at a negedge; returns at the negedge after the command is accepted.
  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_ready: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== 35'h0) begin
      bad++; $display("FAIL rst_rsp: got v=%b w=%b e=%b d=%h want all 0", rsp_valid, rsp_write, rsp_err, rsp_rdata);
    end
    total++;
    if ({chip_select, write_en, read_en, addr, write_data} !== 43'h0) begin
      bad++; $display("FAIL rst_bus: got cs=%b we=%b re=%b a=%h wd=%h want all 0", chip_select, write_en, read_en, addr, write_data);
    end
    total++;
    if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    rsp_ready = 1'b0;
    push(1'b1, 8'h04, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if ({chip_select, write_en, read_en, addr, write_data} !== {3'b110, 8'h04, 32'hDEADBEEF}) begin
      bad++; $display("FAIL wr_bus: got cs=%b we=%b re=%b a=%h wd=%h want 1 1 0 04 deadbeef", chip_select, write_en, read_en, addr, write_data);
    end
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b110, 32'h0}) begin
      bad++; $display("FAIL wr_rsp: got v=%b w=%b e=%b d=%h want 1 1 0 0", rsp_valid, rsp_write, rsp_err, rsp_rdata);
    end
    total++;
    if ({chip_select, write_en, addr, write_data} !== 42'h0) begin
      bad++; $display("FAIL wr_resp_bus: got cs=%b we=%b a=%h wd=%h want 0", chip_select, write_en, addr, write_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_drop: rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_read();
    push(1'b0, 8'h08, 32'h0);
    @(negedge clk);
    total++;
    if ({chip_select, write_en, read_en, addr, rsp_valid} !== {3'b101, 8'h08, 1'b0}) begin
      bad++; $display("FAIL rd_cycle_r: got cs=%b we=%b re=%b a=%h v=%b want 1 0 1 08 0", chip_select, write_en, read_en, addr, rsp_valid);
    end
    @(negedge clk);
    total++;
    if ({read_en, addr, rsp_valid} !== {1'b1, 8'h08, 1'b0}) begin
      bad++; $display("FAIL rd_cycle_r1: got re=%b a=%h v=%b want 1 08 0", read_en, addr, rsp_valid);
    end
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, read_en} !== {3'b100, 32'h12345678, 1'b0}) begin
      bad++; $display("FAIL rd_rsp: got v=%b w=%b e=%b d=%h re=%b want 1 0 0 12345678 0", rsp_valid, rsp_write, rsp_err, rsp_rdata, read_en);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_read_wait();
    int n = 0;
    resp_en = 1'b0;
    push(1'b0, 8'h20, 32'h0);
    @(negedge clk);
`ifdef REGBUS_MASTER_TIMEOUT_EN
    while (read_en && n < 40) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 15) begin bad++; $display("FAIL to_cycles: read_en held %0d cycles want 15", n); end
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, read_en} !== {3'b101, 32'h0, 1'b0}) begin
      bad++; $display("FAIL to_rsp: got v=%b w=%b e=%b d=%h re=%b want 1 0 1 0 0", rsp_valid, rsp_write, rsp_err, rsp_rdata, read_en);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (read_en !== 1'b1 || rsp_valid !== 1'b0) n++;
      @(negedge clk);
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL wait_hold: %0d cycles without read_en/with rsp_valid want 0", n); end
    resp_en = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b100, 32'hA5A50020}) begin
      bad++; $display("FAIL wait_rsp: got v=%b w=%b e=%b d=%h want 1 0 0 a5a50020", rsp_valid, rsp_write, rsp_err, rsp_rdata);
    end
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    resp_en   = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic        w   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  a   [5] = '{8'h10, 8'h14, 8'h10, 8'h18, 8'h14};
    logic [31:0] d   [5] = '{32'h11111111, 32'h22222222, 32'h0, 32'h33333333, 32'h0};
    logic [31:0] rd  [5] = '{32'h0, 32'h0, 32'h11111111, 32'h0, 32'h22222222};
    rsp_ready = 1'b0;
    act_q.delete(); rsp_q.delete(); exp_q.delete(); exp_rsp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({w[i], a[i], d[i]});
      exp_rsp_q.push_back({w[i], 1'b0, rd[i]});
      cmd_valid = 1'b1; cmd_write = w[i]; cmd_addr = a[i]; cmd_wdata = d[i];
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: cmd_ready=%b want 0", cmd_ready); end
    rsp_ready = 1'b1;
    while (rsp_q.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    total++;
    if (act_q.size() != 5 || rsp_q.size() != 5) begin
      bad++; $display("FAIL b2b_count: accesses=%0d responses=%0d want 5 5", act_q.size(), rsp_q.size());
    end
    for (int i = 0; i < 5 && i < act_q.size() && i < rsp_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_bus_%0d: got %h want %h", i, act_q[i], exp_q[i]); end
      total++;
      if (rsp_q[i] !== exp_rsp_q[i]) begin bad++; $display("FAIL b2b_rsp_%0d: got %h want %h", i, rsp_q[i], exp_rsp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    rsp_ready = 1'b0;
    push(1'b0, 8'h20, 32'h0);
    push(1'b1, 8'h24, 32'h55AA55AA);
    act_q.delete(); rsp_q.delete();
    total++;
    if (read_en !== 1'b1) begin bad++; $display("FAIL mid_in_rd: read_en=%b want 1", read_en); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({chip_select, write_en, read_en, addr, write_data, rsp_valid, rsp_write, rsp_err, rsp_rdata, cmd_ready} !== 79'h0) begin
      bad++; $display("FAIL mid_rst_out: cs=%b re=%b a=%h v=%b d=%h rdy=%b want all 0", chip_select, read_en, addr, rsp_valid, rsp_rdata, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    rsp_ready = 1'b1;
    repeat (12) @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (act_q.size() != 0 || rsp_q.size() != 0) begin
      bad++; $display("FAIL mid_drop: accesses=%0d responses=%0d want 0 0", act_q.size(), rsp_q.size());
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_rd_then_wr();
    int n = 0;
    int early = 0;
    rsp_ready = 1'b0;
    push(1'b0, 8'h30, 32'h0);
    push(1'b1, 8'h30, 32'hCAFEF00D);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b100, 32'h0BADF00D}) begin
      bad++; $display("FAIL rw_rd_rsp: got v=%b w=%b e=%b d=%h want 1 0 0 0badf00d", rsp_valid, rsp_write, rsp_err, rsp_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (write_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL rw_hold: %0d cycles with early write or unstable response want 0", early); end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({write_en, rsp_valid} !== 2'b00) begin bad++; $display("FAIL rw_idle: we=%b v=%b want 0 0", write_en, rsp_valid); end
    @(negedge clk);
    total++;
    if ({write_en, addr, write_data} !== {1'b1, 8'h30, 32'hCAFEF00D}) begin
      bad++; $display("FAIL rw_wr_bus: we=%b a=%h wd=%h want 1 30 cafef00d", write_en, addr, write_data);
    end
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b110, 32'h0}) begin
      bad++; $display("FAIL rw_wr_rsp: got v=%b w=%b e=%b d=%h want 1 1 0 0", rsp_valid, rsp_write, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_exclusive();
    total++;
    if (excl_bad != 0) begin bad++; $display("FAIL excl: write_en&&read_en seen %0d times want 0", excl_bad); end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_read_wait();
    test_back_to_back();
    test_reset_mid();
    test_rd_then_wr();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbus_master.md
REGBUS_MASTER -- requirements
Module: regbus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), command queue depth.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 15, max read wait cycles.
REQ-005 SHALL have a single clock and an asynchronous active-low reset: clk input 1 (all logic on rising edge) and rst_n input 1 (asynchronous, active-low), listed first.
REQ-006 SHALL have cmd_valid input 1, cmd_ready output 1, cmd_write input 1 (1=write), cmd_addr input ADDR_WIDTH, cmd_wdata input DATA_WIDTH: command push.
REQ-007 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_write output 1, rsp_err output 1, rsp_rdata output DATA_WIDTH: response.
REQ-008 SHALL have addr output ADDR_WIDTH, chip_select output 1, write_en output 1, read_en output 1, write_data output DATA_WIDTH: bus request to a register-file responder.
REQ-009 SHALL have read_data input DATA_WIDTH and data_valid input 1: bus return (read_data combinational while read active; data_valid registered, one cycle after read).

Function
REQ-010 SHALL push a command when cmd_valid && cmd_ready; cmd_ready = !fifo_full, even if a pop occurs the same cycle.
REQ-011 SHALL implement FSM states IDLE, WR, RD, RESP.
REQ-012 IDLE: if FIFO non-empty, pop head and go WR (cmd_write=1) or RD (cmd_write=0) next cycle; else stay.
REQ-013 WR: drive chip_select=1, write_en=1, addr, write_data for exactly one cycle; go RESP with rsp_write=1, rsp_err=0, rsp_rdata=0.
REQ-014 RD: hold chip_select=1, read_en=1, addr stable until data_valid sampled 1; capture read_data that cycle into rsp_rdata; go RESP with rsp_write=0, rsp_err=0.
REQ-015 Read latency: read_en asserted cycle R, data_valid at R+1, rsp_valid at R+2.
REQ-016 RESP: rsp_valid=1, payload stable, bus signals all 0; on rsp_ready go IDLE.
REQ-017 Bus outputs SHALL be 0 in IDLE and RESP; addr/write_data SHALL be 0 when chip_select=0.
REQ-018 data_valid SHALL be ignored outside RD (covers the trailing data_valid after RD exit).
REQ-019 Command queue SHALL accept pushes while FSM is in any state, including RESP under backpressure.
REQ-020 write_en and read_en SHALL never be asserted together.

Reset
REQ-021 On rst_n low SHALL immediately: FSM=IDLE, FIFO empty, cmd_ready=0 during reset and 1 after, rsp_valid/rsp_write/rsp_err=0, rsp_rdata=0, all bus outputs 0.
REQ-022 Reset mid-access or mid-response SHALL drop the transaction; no response issued for it.

Configuration
REQ-023 Macro REGBUS_MASTER_TIMEOUT_EN defined: a counter runs in RD; if data_valid not seen within TIMEOUT_CYCLES cycles of read_en assertion, SHALL exit RD to RESP with rsp_err=1, rsp_rdata=0.
REQ-024 Macro undefined: no counter; RD waits indefinitely; rsp_err is constant 0.

Structure
REQ-025 Shared package regbus_pkg SHALL hold the FSM state enum, default width constants, and the command record typedef (write, addr, wdata).
REQ-026 Command queue SHALL be sub-module regbus_cmd_fifo (synchronous FIFO, full/empty flags, push/pop).

Verification
REQ-027 Write cmd addr=0x04 data=0xDEADBEEF -> one cycle chip_select=write_en=1 addr=0x04 write_data=0xDEADBEEF; next cycle rsp_valid, rsp_write=1, rsp_err=0.
REQ-028 Read cmd addr=0x08, responder returns 0x12345678 -> read_en held 2 cycles, rsp_rdata=0x12345678 at R+2.
REQ-029 Push 5 cmds back-to-back with rsp_ready=0 -> cmd_ready falls after 4th queued; order of bus accesses matches push order once rsp_ready=1.
REQ-030 With macro defined, read with data_valid tied 0 -> after 15 cycles rsp_err=1, rsp_rdata=0, read_en drops.
REQ-031 Assert rst_n low during RD -> all outputs 0 immediately, FIFO empty, no response after release.
REQ-032 Read followed by write to same address -> write_en asserted only after RESP handshake; trailing data_valid ignored.
